// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: owns the PC, reads the combinational ROM and
// holds one fetched instruction in an IF/ID register with a valid/ready handshake.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] instr_addr,
    input  logic [31:0] instr_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        misalign_err,
    output logic [31:0] retired_cnt
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] instr_nx, ipc_nx, ipc4_nx, cnt_nx;
    logic        mis_nx;
    logic        handshake, slot_free;

    assign instr_addr = pc;
    assign id_valid   = (state == FULL);
    assign handshake  = (state == FULL) && id_ready;
    assign slot_free  = (state == EMPTY) || id_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= EMPTY;
            pc           <= RESET_PC;
            id_instr     <= NOP;
            id_pc        <= '0;
            id_pc_plus4  <= 32'd4;
            misalign_err <= 1'b0;
            retired_cnt  <= '0;
        end else begin
            state        <= state_nx;
            pc           <= pc_nx;
            id_instr     <= instr_nx;
            id_pc        <= ipc_nx;
            id_pc_plus4  <= ipc4_nx;
            misalign_err <= mis_nx;
            retired_cnt  <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        instr_nx = id_instr;
        ipc_nx   = id_pc;
        ipc4_nx  = id_pc_plus4;
        cnt_nx   = handshake ? retired_cnt + 32'd1 : retired_cnt;
        mis_nx   = redirect_valid && (redirect_target[1:0] != 2'b00);

        // A redirect flushes only the valid bit; the held id_* fields stay as-is.
        if (redirect_valid) begin
            state_nx = EMPTY;
            pc_nx    = {redirect_target[31:2], 2'b00};
        end else if (slot_free) begin
            state_nx = FULL;
            instr_nx = instr_data;
            ipc_nx   = pc;
            ipc4_nx  = pc + 32'd4;
            pc_nx    = pc + PC_STEP;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal expectations
// plus a cycle-level reference model compared on every falling edge.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_addr, instr_data, redirect_target;
    logic        redirect_valid, id_ready;
    logic        id_valid, misalign_err;
    logic [31:0] id_instr, id_pc, id_pc_plus4, retired_cnt;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
        .clk(clk), .reset(reset), .instr_addr(instr_addr), .instr_data(instr_data),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_pc_plus4(id_pc_plus4), .misalign_err(misalign_err), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0011_0233 : ((a << 8) | 32'h13);
    endfunction

    assign instr_data = rom(instr_addr);

    // Reference model: one fetch slot, stepped once per edge from the same inputs
    logic [31:0] m_pc, m_instr, m_ipc, m_cnt;
    logic        m_valid, m_mis;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h13;
            m_ipc = 32'h0; m_cnt = 32'h0; m_mis = 1'b0;
        end else begin
            if (m_valid && id_ready) m_cnt = m_cnt + 1;
            m_mis = redirect_valid && (redirect_target % 4 != 0);
            if (redirect_valid) begin
                m_pc    = redirect_target - (redirect_target % 4);
                m_valid = 1'b0;
            end else if (!m_valid || id_ready) begin
                m_instr = rom(m_pc);
                m_ipc   = m_pc;
                m_valid = 1'b1;
                m_pc    = m_pc + 4;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model.instr_addr", instr_addr, m_pc);
        check("model.id_valid", {31'b0, id_valid}, {31'b0, m_valid});
        check("model.id_instr", id_instr, m_instr);
        check("model.id_pc", id_pc, m_ipc);
        check("model.id_pc_plus4", id_pc_plus4, m_ipc + 32'd4);
        check("model.misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
        check("model.retired_cnt", retired_cnt, m_cnt);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] cnt_save;

    initial begin
        reset = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0; redirect_target = '0;
        step(); step();
        check("rst.instr_addr", instr_addr, 32'h0);
        check("rst.id_valid", {31'b0, id_valid}, 32'h0);
        reset = 1'b0;

        step();
        check("first.id_valid", {31'b0, id_valid}, 32'h1);
        check("first.id_instr", id_instr, 32'h0011_0233);
        check("first.id_pc", id_pc, 32'h0);
        check("first.id_pc_plus4", id_pc_plus4, 32'h4);
        check("first.instr_addr", instr_addr, 32'h4);

        step();
        id_ready = 1'b0;
        cnt_save = retired_cnt;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall.id_pc", id_pc, 32'h4);
            check("stall.id_instr", id_instr, rom(32'h4));
            check("stall.instr_addr", instr_addr, 32'h8);
            check("stall.cnt", retired_cnt, 32'd1);
        end
        id_ready = 1'b1;
        step();
        check("resume.id_pc", id_pc, 32'h8);
        check("resume.cnt", retired_cnt, cnt_save + 32'd1);

        step(); step(); step();
        check("pre_br.id_pc", id_pc, 32'h14);
        cnt_save = retired_cnt;
        redirect_valid = 1'b1; redirect_target = 32'h20;
        step();
        redirect_valid = 1'b0;
        check("br.id_valid", {31'b0, id_valid}, 32'h0);
        check("br.instr_addr", instr_addr, 32'h20);
        check("br.cnt", retired_cnt, cnt_save + 32'd1);
        step();
        check("br.id_pc", id_pc, 32'h20);
        check("br.id_valid2", {31'b0, id_valid}, 32'h1);

        cnt_save = retired_cnt;
        id_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h8;
        step();
        redirect_valid = 1'b0;
        check("stall_br.id_valid", {31'b0, id_valid}, 32'h0);
        check("stall_br.instr_addr", instr_addr, 32'h8);
        check("stall_br.cnt", retired_cnt, cnt_save);
        id_ready = 1'b1;
        step();
        check("stall_br.id_pc", id_pc, 32'h8);

        redirect_valid = 1'b1; redirect_target = 32'h22;
        step();
        redirect_valid = 1'b0;
        check("mis.instr_addr", instr_addr, 32'h20);
        check("mis.err_hi", {31'b0, misalign_err}, 32'h1);
        step();
        check("mis.err_lo", {31'b0, misalign_err}, 32'h0);
        check("mis.id_pc", id_pc, 32'h20);

        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        check("wrap.instr_addr0", instr_addr, 32'hFFFF_FFFC);
        step();
        check("wrap.id_pc", id_pc, 32'hFFFF_FFFC);
        check("wrap.id_pc_plus4", id_pc_plus4, 32'h0);
        check("wrap.instr_addr", instr_addr, 32'h0);

        #2 reset = 1'b1;
        #1;
        check("arst.instr_addr", instr_addr, 32'h0);
        check("arst.id_valid", {31'b0, id_valid}, 32'h0);
        check("arst.id_instr", id_instr, 32'h13);
        check("arst.id_pc", id_pc, 32'h0);
        check("arst.id_pc_plus4", id_pc_plus4, 32'h4);
        check("arst.misalign", {31'b0, misalign_err}, 32'h0);
        check("arst.cnt", retired_cnt, 32'h0);
        step();
        reset = 1'b0;

        for (int i = 0; i < 60; i++) begin
            id_ready        = (i % 3) != 2;
            redirect_valid  = (i % 11) == 7;
            redirect_target = 32'h40 + 32'(i % 4) + 32'(i * 8);
            step();
        end
        redirect_valid = 1'b0;
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
